// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// default operand width, FSM state encoding and product-width helper.
package mult_pkg;

    localparam int MULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Product of two w-bit unsigned operands needs 2*w bits.
    function automatic int prod_w(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/pp_row_and.sv
// Partial-product row gating: every bit of the shifted multiplicand is
// ANDed with the current multiplier bit. Purely combinational.
module pp_row_and #(
    parameter int W = 64
) (
    input  logic [W-1:0] vec_i,
    input  logic         bit_i,
    output logic [W-1:0] row_o
);

    assign row_o = vec_i & {W{bit_i}};

endmodule

// File: rtl/seq_shift_add_mult.sv
// Iterative unsigned shift-and-add multiplier: one gated partial-product
// row is accumulated per clock into a 2*WIDTH product.
// Optional build macro MULT_EARLY_TERM_EN: leave RUN as soon as no
// multiplier ones remain (result unchanged, latency data dependent).
// DONE is a registered one-cycle pulse asserted on the edge that retires
// FIN, so DONE appears WIDTH+1 edges after the accepting START edge.
module seq_shift_add_mult
    import mult_pkg::*;
#(
    parameter  int WIDTH = MULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH),
    localparam int PW    = prod_w(WIDTH)
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [PW-1:0]    PRODUCT
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [PW-1:0]    a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [PW-1:0]    acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [PW-1:0]    product_q;

    logic [PW-1:0]    row;
    logic [PW-1:0]    acc_d;
    logic [WIDTH-1:0] b_sh_d;
    logic             last_d;

    pp_row_and #(
        .W(PW)
    ) u_row (
        .vec_i(a_sh_q),
        .bit_i(b_sh_q[0]),
        .row_o(row)
    );

    // Next accumulator, shifted multiplier and RUN-exit decision.
    always_comb begin
        acc_d  = acc_q + row;
        b_sh_d = b_sh_q >> 1;
`ifdef MULT_EARLY_TERM_EN
        last_d = (cnt_q == LAST_CNT) || (b_sh_d == '0);
`else
        last_d = (cnt_q == LAST_CNT);
`endif
    end

    // Control FSM with datapath registers and registered handshake outputs.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q   <= IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (START) begin
                        a_sh_q  <= PW'(A);
                        b_sh_q  <= B;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    acc_q  <= acc_d;
                    a_sh_q <= a_sh_q << 1;
                    b_sh_q <= b_sh_d;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (last_d) begin
                        product_q <= acc_d;
                        state_q   <= FIN;
                    end
                end
                FIN: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign PRODUCT = product_q;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Self-checking bench for seq_shift_add_mult (WIDTH = 32).
module tb_seq_shift_add_mult;

    logic        CLK;
    logic        RSTn;
    logic        START;
    logic [31:0] A;
    logic [31:0] B;
    logic        BUSY;
    logic        DONE;
    logic [63:0] PRODUCT;

    int vectors;
    int miscompares;

    seq_shift_add_mult #(.WIDTH(32)) dut (
        .CLK(CLK),
        .RSTn(RSTn),
        .START(START),
        .A(A),
        .B(B),
        .BUSY(BUSY),
        .DONE(DONE),
        .PRODUCT(PRODUCT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: edges from accepting START edge to the DONE cycle.
    function automatic int exp_latency(input logic [31:0] b);
`ifdef MULT_EARLY_TERM_EN
        int hi;
        hi = 0;
        for (int i = 0; i < 32; i++) if (b[i]) hi = i;
        return hi + 2;
`else
        return 33;
`endif
    endfunction

    // Issue one operation and check latency, product, pulse width, idle return.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input bit inject_start, input bit check_hold,
                          input logic [63:0] prev);
        int          lat;
        int          el;
        logic [63:0] ep;
        el = exp_latency(b);
        ep = 64'(a) * 64'(b);
        START = 1'b1; A = a; B = b;
        @(posedge CLK); #1;
        START = 1'b0; A = $urandom; B = $urandom;
        chk("busy_after_start", 64'(BUSY), 64'd1);
        lat = 0;
        while (lat < 100 && DONE !== 1'b1) begin
            if (inject_start && lat == 3) begin
                START = 1'b1; A = 32'd9; B = 32'd9;
            end else if (inject_start && lat == 4) begin
                START = 1'b0;
            end
            if (check_hold && lat == el - 2) chk("product_held", PRODUCT, prev);
            @(posedge CLK); #1;
            lat++;
        end
        START = 1'b0;
        chk("latency", 64'(lat), 64'(el));
        chk("product", PRODUCT, ep);
        @(posedge CLK); #1;
        chk("done_one_cycle", 64'(DONE), 64'd0);
        chk("idle_after_done", 64'(BUSY), 64'd0);
        chk("product_kept", PRODUCT, ep);
    endtask

    initial begin
        logic [63:0] last_p;
        logic [31:0] ra;
        logic [31:0] rb;
        bit          saw_done;
        vectors = 0;
        miscompares = 0;
        RSTn = 1'b0; START = 1'b0; A = '0; B = '0;
        #23;
        chk("reset_busy", 64'(BUSY), 64'd0);
        chk("reset_done", 64'(DONE), 64'd0);
        chk("reset_product", PRODUCT, 64'd0);
        @(negedge CLK); RSTn = 1'b1;
        @(negedge CLK);

        // Abort mid-RUN with asynchronous reset.
        START = 1'b1; A = 32'd5; B = 32'd7;
        @(posedge CLK); #1; START = 1'b0;
        repeat (3) @(posedge CLK);
        #2 RSTn = 1'b0;
        #1;
        chk("abort_busy", 64'(BUSY), 64'd0);
        chk("abort_product", PRODUCT, 64'd0);
        chk("abort_done", 64'(DONE), 64'd0);
        repeat (2) @(posedge CLK);
        #2 RSTn = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge CLK); #1;
            if (DONE === 1'b1) saw_done = 1'b1;
        end
        chk("no_done_after_abort", 64'(saw_done), 64'd0);
        run_op(32'd5, 32'd7, 1'b0, 1'b0, 64'd0);

        // Basic, max and ignored START.
        run_op(32'h0000_000C, 32'h0000_000A, 1'b0, 1'b0, 64'd0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'd0);
        chk("max_const", PRODUCT, 64'hFFFF_FFFE_0000_0001);
        run_op(32'd3, 32'd4, 1'b1, 1'b0, 64'd0);
        saw_done = 1'b0;
        repeat (3) begin
            @(posedge CLK); #1;
            if (BUSY === 1'b1 || DONE === 1'b1) saw_done = 1'b1;
        end
        chk("ignored_start_no_restart", 64'(saw_done), 64'd0);
        chk("ignored_start_product", PRODUCT, 64'd12);

        // Back-to-back issue in the cycle after DONE.
        last_p = PRODUCT;
        run_op(32'h0001_0000, 32'h0001_0000, 1'b0, 1'b1, last_p);
        chk("b2b_const", PRODUCT, 64'h1_0000_0000);

`ifdef MULT_EARLY_TERM_EN
        run_op(32'd7, 32'd0, 1'b0, 1'b0, 64'd0);
        run_op(32'd3, 32'h8000_0000, 1'b0, 1'b0, 64'd0);
        chk("early_term_msb_const", PRODUCT, 64'h1_8000_0000);
`endif

        // Randomized operands, chained back to back.
        for (int k = 0; k < 10; k++) begin
            last_p = PRODUCT;
            ra = $urandom;
            rb = $urandom;
            if (k % 3 == 1) rb = rb >> $urandom_range(31, 1);
            if (k == 7) ra = 32'd0;
            run_op(ra, rb, 1'b0, 1'b1, last_p);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
